btn_arbiter: RTL
================

# btn_arbiter

- Shares one downstream resource (display/counter update unit) among `N` button inputs.
- Detects rising edges on each button internally, latches them as pending requests, and grants one at a time in round-robin order.
- Each grant is a one-cycle pulse with the winning index; the arbiter then holds `busy` until the resource returns `done`.
- Sits between the debounced button inputs and the shared datapath.

## Interface
- `N`, 4: number of button requesters (2..8).
- `IDX_W`, 2: width of `grant_idx`; must satisfy 2^IDX_W >= N.
- `TIMEOUT`, 15: cycles spent in WAIT before abort (used only with the macro).

- `clk`  input  1  system clock, all state on rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted at 0).
- `btn`  input  N  level button inputs, already synchronous to `clk`.
- `done`  input  1  resource finished the current grant; sampled only in WAIT.
- `grant_valid`  output  1  one-cycle grant pulse.
- `grant_idx`  output  IDX_W  winning channel; valid while `grant_valid`=1, holds value afterwards.
- `busy`  output  1  high in GRANT and WAIT.
- `pending`  output  N  latched, unserved requests.
- `timeout_err`  output  1  one-cycle abort pulse.

## Operation
- Reset values:
  - state=IDLE.
  - `grant_valid`=0, `grant_idx`=0, `busy`=0, `pending`=0, `timeout_err`=0.
  - Round-robin pointer `ptr`=0.
  - Previous-sample register `btn_q`=all ones, so a button held through reset is not an edge.
- Edge detect, per channel i: `edge[i] = btn[i] & ~btn_q[i]`; `btn_q <= btn` every cycle.
- Pending latch:
  - An `edge[i]` sets `pending[i]`.
  - Being granted clears `pending[i]`.
  - Set and clear in the same cycle on the same channel: set wins.
  - Repeated edges on a channel that is already pending coalesce into one request.
- Selection: starting at `ptr`, search upward modulo N; the first set `pending` bit wins.
- FSM:
  - IDLE: if any `pending` bit is set, go to GRANT. Register the winner into `grant_idx`, clear that pending bit, and set `ptr <= (idx+1) mod N` (N-1 wraps to 0).
  - GRANT: `grant_valid`=1 and `busy`=1 for exactly one cycle, then go to WAIT.
  - WAIT: `busy`=1. If `done`=1, go to IDLE. `done` seen in IDLE or GRANT is ignored.
- Edges arriving in GRANT or WAIT are still latched and are served later.
- Reset asserted mid-operation: all state returns immediately to reset values, and pending requests are discarded.

## Timing
- `btn[i]` goes 0→1 before clock edge k:
  - `pending[i]`=1 after edge k.
  - GRANT after edge k+1.
  - WAIT after edge k+2.
- Best-case latency from sampled press to `grant_valid`: 2 cycles.
- `done` high before edge m while in WAIT: IDLE after m. If a request is pending, the next GRANT follows after m+1.
- Minimum spacing between `grant_valid` pulses: 3 cycles.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.

## Configuration
- `BTN_ARB_TIMEOUT_EN` defined:
  - A counter clears on WAIT entry and increments each WAIT cycle.
  - If `done` has not arrived after TIMEOUT cycles in WAIT, the FSM returns to IDLE and `timeout_err` pulses for one cycle.
  - `ptr` has already advanced, and the aborted request is not re-pended.
  - If `done` and the timeout occur in the same cycle, `done` wins and there is no error.
- `BTN_ARB_TIMEOUT_EN` undefined: WAIT lasts until `done` indefinitely; `timeout_err` is tied to 0 and no counter is built.

## Test plan
- Reset with `btn`=4'b0001 held, then release of reset → no pending bit set and no grant; drop `btn[0]` and raise it again → `grant_valid` with `grant_idx`=0 two cycles later.
- `btn`=4'b1010 rising in the same cycle, `ptr`=0 → grant idx 1; `done`; then grant idx 3; then `ptr`=0.
- Sequential presses 3, then 0, each served with `done` 1 cycle after WAIT entry → idx 3 then idx 0 (pointer wrap 3→0); `grant_valid` pulses exactly 3 cycles apart.
- Press ch2 during WAIT for ch1, and press ch1 again three times → ch1 pending as a single request, ch2 pending; after `done`, grant idx 2 first (ptr=2), then idx 1.
- Hold `done`=1 continuously, single press ch0 → exactly one grant, and `busy` stays high for 2 cycles.
- With `BTN_ARB_TIMEOUT_EN`, TIMEOUT=15, grant ch1 and never assert `done` → `timeout_err` pulses once and the FSM returns to IDLE; without the macro → `busy` stays 1 and `timeout_err` stays 0. Asserting `rst`=0 mid-WAIT → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/btn_arbiter.sv
// -----------------------------------------------------------------------------
// btn_arbiter
//
// Shares one downstream resource (display/counter update unit) among N
// debounced button inputs. Rising edges on each button are detected
// internally and latched as pending requests. Requests are granted one at a
// time in round-robin order. Each grant is a one-cycle pulse carrying the
// winning index, and the arbiter then holds busy until the resource reports
// done.
//
// Optional feature (compile-time macro):
//   BTN_ARB_TIMEOUT_EN - when defined, WAIT is abandoned after TIMEOUT cycles
//                        without done, and timeout_err pulses for one cycle.
//                        When undefined, WAIT lasts until done, timeout_err is
//                        tied low and no counter is built.
//
// Parameters:
//   N        number of button requesters (2..8)
//   IDX_W    width of grant_idx, 2**IDX_W >= N
//   TIMEOUT  WAIT cycles before abort (only used with BTN_ARB_TIMEOUT_EN)
//
// Ports:
//   clk          in   system clock, all state on the rising edge
//   rst          in   asynchronous reset, active low
//   btn          in   [N] level button inputs, synchronous to clk
//   done         in   resource finished the current grant (sampled in WAIT)
//   grant_valid  out  one-cycle grant pulse
//   grant_idx    out  [IDX_W] winning channel, holds after the pulse
//   busy         out  high in GRANT and WAIT
//   pending      out  [N] latched, unserved requests
//   timeout_err  out  one-cycle abort pulse
//   state_dbg    out  [2] current FSM state (0=IDLE, 1=GRANT, 2=WAIT)
//   ptr_dbg      out  [IDX_W] round-robin search start pointer
//
// Handshake: grant_valid is a one-cycle pulse with no back-pressure; the
// resource acknowledges completion by raising done while busy is high in
// WAIT. done outside WAIT has no effect.
// -----------------------------------------------------------------------------
module btn_arbiter #(
  parameter int N       = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     btn,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic [N-1:0]     pending,
  output logic             timeout_err,
  output logic [1:0]       state_dbg,
  output logic [IDX_W-1:0] ptr_dbg
);

  // Elaboration-time parameter sanity check.
  if (N < 2 || N > 8 || (2 ** IDX_W) < N || TIMEOUT < 1) begin : g_param_check
    $error("btn_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  logic [N-1:0]     btn_q;
  logic [N-1:0]     btn_edge;
  logic [IDX_W-1:0] ptr;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W:0]   cand;
  logic [IDX_W:0]   ptr_inc;
  logic [IDX_W-1:0] ptr_nxt;
  logic             grant_now;
  logic [N-1:0]     clr_mask;

  // ---------------------------------------------------------------------------
  // Edge detection. btn_q resets to all ones so that a button already held
  // while reset is asserted does not look like a fresh press on release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= '1;
    end else begin
      btn_q <= btn;
    end
  end

  assign btn_edge = btn & ~btn_q;

  // ---------------------------------------------------------------------------
  // Round-robin selection: walk from ptr upward modulo N, first pending bit
  // wins. The candidate index is one bit wider than IDX_W so ptr+i (< 2N)
  // never overflows before the single wrap subtraction.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      for (int j = 0; j < N; j++) begin
        if (!sel_found && (cand == (IDX_W+1)'(j)) && pending[j]) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(j);
        end
      end
    end
  end

  // Pointer moves to the channel after the winner, wrapping N-1 to 0.
  always_comb begin
    ptr_inc = {1'b0, sel_idx} + (IDX_W+1)'(1);
    ptr_nxt = ptr_inc[IDX_W-1:0];
    if (ptr_inc == (IDX_W+1)'(N)) begin
      ptr_nxt = '0;
    end
  end

  // A grant is issued only from IDLE, from the registered pending vector.
  assign grant_now = (state == S_IDLE) && sel_found;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = grant_now && (sel_idx == IDX_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Pending latch. The clear is applied before the set, so an edge arriving
  // on the channel being granted in the same cycle survives as a new request.
  // Repeated edges on an already-pending channel simply re-set the same bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | btn_edge;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
`ifdef BTN_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      ptr         <= '0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      grant_valid <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            state       <= S_GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= sel_idx;
            ptr         <= ptr_nxt;
            busy        <= 1'b1;
          end
        end
        S_GRANT: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          // done takes priority over an abort landing in the same cycle.
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // The aborted request is dropped; ptr already moved past it.
            state       <= S_IDLE;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      busy        <= 1'b0;
      ptr         <= '0;
    end else begin
      grant_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_now) begin
            state       <= S_GRANT;
            grant_valid <= 1'b1;
            grant_idx   <= sel_idx;
            ptr         <= ptr_nxt;
            busy        <= 1'b1;
          end
        end
        S_GRANT: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign timeout_err = 1'b0;
`endif

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule
